// File: rtl/lifo_stack_ctrl.sv
// lifo_stack_ctrl: LIFO stack built from a top-of-stack register and a
// single-port RAM with 1-cycle read latency. The RAM holds every element
// below the top, so the current top is always visible without a RAM read.
// A pop with elements left below the top costs one REFILL cycle to reload
// the top register from RAM.
module lifo_stack_ctrl #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_valid,
    output logic              pop_ready,
    output logic [DATA_W-1:0] top_data,
    output logic              top_valid,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int RAM_WORDS = DEPTH - 1;
    localparam int AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    typedef enum logic {IDLE, REFILL} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   top_q, top_d;
    logic                top_valid_q, top_valid_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic [DATA_W-1:0]   ram_q [RAM_WORDS];
    logic [DATA_W-1:0]   ram_dout_q;
    logic                ram_we, ram_re;
    logic [AW-1:0]       ram_addr;

    logic                is_idle, is_empty, is_full;
    logic                push_fire, pop_fire;

    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == CNT_W'(DEPTH));
    assign push_fire = push_valid & push_ready;
    assign pop_fire  = pop_valid & pop_ready;

    assign top_data  = top_q;
    assign top_valid = top_valid_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign ovf_err   = ovf_q;
    assign udf_err   = udf_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only a plain pop leaving elements in RAM needs a refill cycle
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (pop_fire && !push_fire && count_q > CNT_W'(1)) state_d = REFILL;
                REFILL:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs: decoded from state/count/pop_valid only, never push_valid
    always_comb begin
        is_idle    = (state_q == IDLE);
        pop_ready  = is_idle & !is_empty;
        push_ready = is_idle & (!is_full | pop_valid);
    end

    // Datapath: top register, occupancy, sticky flags and RAM control
    always_comb begin
        count_d     = count_q;
        top_d       = top_q;
        top_valid_d = top_valid_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = AW'(count_q - CNT_W'(1));

        if (clr) begin
            count_d     = '0;
            top_d       = '0;
            top_valid_d = 1'b0;
            ovf_d       = 1'b0;
            udf_d       = 1'b0;
        end else if (state_q == REFILL) begin
            top_d       = ram_dout_q;
            top_valid_d = 1'b1;
        end else begin
            if (is_full && push_valid && !pop_valid) ovf_d = 1'b1;
            if (is_empty && pop_valid)               udf_d = 1'b1;

            if (push_fire && pop_fire) begin
                top_d = push_data;
            end else if (push_fire) begin
                top_d       = push_data;
                top_valid_d = 1'b1;
                count_d     = count_q + CNT_W'(1);
                // Spill the old top into RAM unless the stack was empty
                if (!is_empty) ram_we = 1'b1;
            end else if (pop_fire) begin
                top_valid_d = 1'b0;
                count_d     = count_q - CNT_W'(1);
                if (count_q > CNT_W'(1)) begin
                    ram_re   = 1'b1;
                    ram_addr = AW'(count_q - CNT_W'(2));
                end
            end
        end
    end

    // Control and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            top_q       <= '0;
            top_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            top_q       <= top_d;
            top_valid_q <= top_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // Single-port RAM: write and read never coincide
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_addr] <= top_q;
        end else if (ram_re) begin
            ram_dout_q <= ram_q[ram_addr];
        end
    end

endmodule
